// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder with valid/ready request handshake
// Optional load/store statistics counters are built when DMEM_STATS_EN is defined.
module dmem_responder #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    input  logic              halt,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     mem_q [2**DEPTH_LOG2];
    logic                  mem_we;

    // Address bits above the word index alias onto the same array entry.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:DEPTH_LOG2+1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        err_d     = err_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // Gate on rst so the initiator never sees ready during reset.
                req_ready = ~halt & rst;
                if (req_valid && !halt) begin
                    wr_d    = req_wr;
                    err_d   = req_addr[0];
                    idx_d   = req_addr[DEPTH_LOG2:1];
                    wdata_d = req_wdata;
                    cnt_d   = 4'd1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(LATENCY - 1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_we    = (state_q == RESP) && wr_q && !err_q;
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = (rsp_valid && !wr_q && !err_q) ? mem_q[idx_q] : '0;

    // Array is deliberately not reset; an aborted store never reaches RESP.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

`ifdef DMEM_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (state_q == RESP && !err_q) begin
            if (wr_q) begin
                if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
            end else begin
                if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    assign rd_count = 16'd0;
    assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder against a word-array reference model
module tb_dmem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        halt;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] ref_mem [256];
    int          exp_rd = 0;
    int          exp_wr = 0;
    time         last_accept = 0;
    time         this_accept = 0;

    dmem_responder #(
        .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .halt(halt),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef DMEM_STATS_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return (n >= 0) ? 16'd0 : 16'd0;
`endif
    endfunction

    // Called at a falling edge; returns at the falling edge one cycle after the response.
    task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic halt_in_busy);
        int n;
        logic [15:0] exp_data;
        logic        exp_e;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, n < 50}, 32'd1);
        last_accept = this_accept;
        this_accept = $time;
        @(negedge clk);
        for (int k = 1; k < LAT; k++) begin
            chk("busy_valid", {31'd0, rsp_valid}, 32'd0);
            chk("busy_ready", {31'd0, req_ready}, 32'd0);
            req_wr    = 1'($urandom);
            req_addr  = 16'($urandom);
            req_wdata = 16'($urandom);
            if (k == 1 && halt_in_busy) halt = 1'b1;
            @(negedge clk);
        end
        exp_e    = addr[0];
        exp_data = (wr || exp_e) ? 16'd0 : ref_mem[addr[8:1]];
        chk("rsp_latency", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_err",     {31'd0, rsp_err}, {31'd0, exp_e});
        chk("rsp_rdata",   {16'd0, rsp_rdata}, {16'd0, exp_data});
        chk("resp_ready",  {31'd0, req_ready}, 32'd0);
        if (!exp_e) begin
            if (wr) begin
                ref_mem[addr[8:1]] = wdata;
                exp_wr++;
            end else begin
                exp_rd++;
            end
        end
        @(negedge clk);
        chk("pulse_valid", {31'd0, rsp_valid}, 32'd0);
        chk("idle_rdata",  {16'd0, rsp_rdata}, 32'd0);
        chk("idle_err",    {31'd0, rsp_err}, 32'd0);
        chk("idle_ready",  {31'd0, req_ready}, {31'd0, ~halt});
        chk("rd_count",    {16'd0, rd_count}, {16'd0, exp_cnt(exp_rd)});
        chk("wr_count",    {16'd0, wr_count}, {16'd0, exp_cnt(exp_wr)});
        req_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] a;
        rst = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; halt = 1'b0;
        #12;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_err",   {31'd0, rsp_err}, 32'd0);
        chk("rst_rdcnt", {16'd0, rd_count}, 32'd0);
        chk("rst_wrcnt", {16'd0, wr_count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready0", {31'd0, req_ready}, 32'd1);

        // Fill every word so later loads have a known reference value.
        for (int i = 0; i < 256; i++) do_req(1'b1, 16'(2 * i), 16'($urandom), 1'b0);

        // Store then load same word.
        do_req(1'b1, 16'h0010, 16'hBEEF, 1'b0);
        do_req(1'b0, 16'h0010, 16'h0000, 1'b0);
        chk("beef", {16'd0, ref_mem[8]}, 32'h0000BEEF);
        // Unaligned load, then neighbouring aligned load.
        do_req(1'b0, 16'h0201, 16'h0000, 1'b0);
        do_req(1'b1, 16'h0201, 16'h5555, 1'b0);
        do_req(1'b0, 16'h0200, 16'h0000, 1'b0);
        // Aliasing across the 512-byte window.
        do_req(1'b1, 16'h0002, 16'h1234, 1'b0);
        do_req(1'b0, 16'h0202, 16'h0000, 1'b0);
        do_req(1'b0, 16'hFE02, 16'h0000, 1'b0);

        // Back-to-back accepts are spaced LATENCY+1 cycles apart.
        for (int i = 0; i < 3; i++) begin
            do_req(1'($urandom), 16'($urandom), 16'($urandom), 1'b0);
            if (i > 0) chk("accept_spacing", 32'((this_accept - last_accept) / 10), LAT + 1);
        end

        // Reset two cycles into a store aborts it.
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0004; req_wdata = 16'hAAAA;
        chk("rst_pre_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd0);
        chk("abort_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("abort_rdcnt", {16'd0, rd_count}, 32'd0);
        chk("abort_wrcnt", {16'd0, wr_count}, 32'd0);
        exp_rd = 0; exp_wr = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_req(1'b0, 16'h0004, 16'h0000, 1'b0);

        // halt raised while busy: response unaffected, then no accepts until released.
        do_req(1'b1, 16'h0030, 16'h0F0F, 1'b1);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0030;
        for (int k = 0; k < 4; k++) begin
            chk("halt_ready", {31'd0, req_ready}, 32'd0);
            chk("halt_valid", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        halt = 1'b0;
        do_req(1'b0, 16'h0030, 16'h0000, 1'b0);
        do_req(1'b0, 16'h0031, 16'h0000, 1'b0);
        do_req(1'b1, 16'h0032, 16'h7777, 1'b0);
        do_req(1'b0, 16'h0032, 16'h0000, 1'b0);

        // Random traffic against the reference model.
        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 7) != 0) a[0] = 1'b0;
            do_req(1'($urandom), a, 16'($urandom), 1'($urandom_range(0, 9) == 0));
            halt = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
